// File: rtl/cnn_pkg.sv
// Shared types and constants for the layer-4 argmax reporter: FSM states,
// hex-digit 7-segment table (active-low {dp,g,f,e,d,c,b,a}) and default score width.
package cnn_pkg;

   localparam int FEAT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_e;

   // dp bit is left high (off); the encoder overrides it
   localparam logic [7:0] SEG7_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/seg7_encoder.sv
// Combinational class-index to active-low 7-segment code; the decimal point
// is lit when dp_on is high. The parent registers the result.
module seg7_encoder
   import cnn_pkg::*;
#(
   parameter int IW = 4
) (
   input  logic [IW-1:0] idx,
   input  logic          dp_on,
   output logic [7:0]    seg
);

   logic [3:0] nib;
   logic [7:0] code;

   assign nib  = 4'(idx);
   assign code = SEG7_LUT[nib];
   assign seg  = {~dp_on, code[6:0]};

endmodule

// File: rtl/class_argmax_reporter.sv
// Layer-4 consumer: captures N_FEAT signed scores on a feat_valid rise, runs a
// one-compare-per-cycle argmax and reports the class. Optional MARGIN_CHECK_EN.
module class_argmax_reporter
   import cnn_pkg::*;
#(
   parameter int N_FEAT = 16,
   parameter int FEAT_W = FEAT_W_DEF,
   parameter int MARGIN = 4,
   localparam int IW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     feat_valid,
   input  logic [N_FEAT*FEAT_W-1:0] feat_in,
   input  logic                     clear,
   output logic                     ack,
   output logic                     busy,
   output logic [IW-1:0]            class_idx,
   output logic                     class_valid,
   output logic [7:0]               seg,
   output logic                     overrun,
   output logic                     low_conf
);

   localparam logic signed [FEAT_W-1:0] MOST_NEG = {1'b1, {(FEAT_W-1){1'b0}}};
   localparam logic [IW-1:0]            LAST_IDX = IW'(N_FEAT - 1);

   state_e                     state_q, state_d;
   logic                       fv_q;
   logic                       rise;
   logic [N_FEAT*FEAT_W-1:0]   feat_buf_q, feat_buf_d;
   logic [IW-1:0]              cnt_q, cnt_d;
   logic signed [FEAT_W-1:0]   best_q, best_d;
   logic [IW-1:0]              best_idx_q, best_idx_d;
   logic [IW-1:0]              class_idx_q, class_idx_d;
   logic                       class_valid_q, class_valid_d;
   logic [7:0]                 seg_q, seg_d;
   logic                       overrun_q, overrun_d;
   logic signed [FEAT_W-1:0]   cur;
   logic signed [FEAT_W-1:0]   nxt_best;
   logic [IW-1:0]              nxt_idx;
   logic                       nxt_low_conf;
   logic [7:0]                 seg_code;

`ifdef MARGIN_CHECK_EN
   localparam logic signed [FEAT_W:0] MARGIN_S = (FEAT_W+1)'(MARGIN);
   logic signed [FEAT_W-1:0]   second_q, second_d;
   logic signed [FEAT_W-1:0]   nxt_second;
   logic signed [FEAT_W:0]     gap;
   logic                       low_conf_q, low_conf_d;
`endif

   assign rise = feat_valid & ~fv_q;
   assign cur  = feat_buf_q[int'(cnt_q)*FEAT_W +: FEAT_W];

   // One scan step: index 0 seeds the running best, later indices replace it only on strictly greater.
   always_comb begin
      nxt_best = best_q;
      nxt_idx  = best_idx_q;
`ifdef MARGIN_CHECK_EN
      nxt_second = second_q;
`endif
      if (cnt_q == '0) begin
         nxt_best = cur;
         nxt_idx  = '0;
`ifdef MARGIN_CHECK_EN
         nxt_second = MOST_NEG;
`endif
      end else if (cur > best_q) begin
         nxt_best = cur;
         nxt_idx  = cnt_q;
`ifdef MARGIN_CHECK_EN
         nxt_second = best_q;
`endif
      end
`ifdef MARGIN_CHECK_EN
      else if (cur > second_q) begin
         nxt_second = cur;
      end
`endif
   end

`ifdef MARGIN_CHECK_EN
   assign gap          = {nxt_best[FEAT_W-1], nxt_best} - {nxt_second[FEAT_W-1], nxt_second};
   assign nxt_low_conf = (gap < MARGIN_S);
`else
   assign nxt_low_conf = 1'b0;
`endif

   seg7_encoder #(.IW(IW)) u_seg7 (
      .idx   (nxt_idx),
      .dp_on (nxt_low_conf),
      .seg   (seg_code)
   );

   always_comb begin
      state_d       = state_q;
      feat_buf_d    = feat_buf_q;
      cnt_d         = cnt_q;
      best_d        = best_q;
      best_idx_d    = best_idx_q;
      class_idx_d   = class_idx_q;
      class_valid_d = class_valid_q;
      seg_d         = seg_q;
      overrun_d     = overrun_q;
`ifdef MARGIN_CHECK_EN
      second_d      = second_q;
      low_conf_d    = low_conf_q;
`endif

      if (clear) begin
         overrun_d     = 1'b0;
         class_valid_d = 1'b0;
      end
      if (rise && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rise) begin
               feat_buf_d = feat_in;
               cnt_d      = '0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            best_d     = nxt_best;
            best_idx_d = nxt_idx;
`ifdef MARGIN_CHECK_EN
            second_d   = nxt_second;
`endif
            if (cnt_q == LAST_IDX) begin
               // Results are loaded on entry to REPORT so they are visible alongside ack.
               class_idx_d   = nxt_idx;
               seg_d         = seg_code;
               class_valid_d = 1'b1;
`ifdef MARGIN_CHECK_EN
               low_conf_d    = nxt_low_conf;
`endif
               state_d       = REPORT;
            end else begin
               cnt_d = cnt_q + IW'(1);
            end
         end
         REPORT: begin
            class_valid_d = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         fv_q          <= 1'b0;
         feat_buf_q    <= '0;
         cnt_q         <= '0;
         best_q        <= '0;
         best_idx_q    <= '0;
         class_idx_q   <= '0;
         class_valid_q <= 1'b0;
         seg_q         <= 8'hFF;
         overrun_q     <= 1'b0;
`ifdef MARGIN_CHECK_EN
         second_q      <= MOST_NEG;
         low_conf_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         fv_q          <= feat_valid;
         feat_buf_q    <= feat_buf_d;
         cnt_q         <= cnt_d;
         best_q        <= best_d;
         best_idx_q    <= best_idx_d;
         class_idx_q   <= class_idx_d;
         class_valid_q <= class_valid_d;
         seg_q         <= seg_d;
         overrun_q     <= overrun_d;
`ifdef MARGIN_CHECK_EN
         second_q      <= second_d;
         low_conf_q    <= low_conf_d;
`endif
      end
   end

   // valid/ready: no backpressure; a feat_valid rise is a request, ack is a single-cycle completion.
   assign ack         = (state_q == REPORT);
   assign busy        = (state_q != IDLE);
   assign class_idx   = class_idx_q;
   assign class_valid = class_valid_q;
   assign seg         = seg_q;
   assign overrun     = overrun_q;
`ifdef MARGIN_CHECK_EN
   assign low_conf    = low_conf_q;
`else
   assign low_conf    = 1'b0;
`endif

endmodule

// File: tb/tb_class_argmax_reporter.sv
// Directed bench for class_argmax_reporter with a scoreboard queue of
// expected {class_idx, seg, low_conf}; honours MARGIN_CHECK_EN when defined.
module tb_class_argmax_reporter;

   localparam int N  = 16;
   localparam int W  = 8;
   localparam int IW = 4;
   localparam int EW = IW + 8 + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           feat_valid;
   logic [N*W-1:0] feat_in;
   logic           clear;
   logic           ack;
   logic           busy;
   logic [IW-1:0]  class_idx;
   logic           class_valid;
   logic [7:0]     seg;
   logic           overrun;
   logic           low_conf;

   int              checks = 0;
   int              errors = 0;
   int              cur_cycle = 0;
   logic [EW-1:0]   exp_q[$];
   logic [7:0]      last_seg;
   logic signed [7:0] sc [N];
   logic [7:0]      lut [16];

   class_argmax_reporter #(.N_FEAT(N), .FEAT_W(W), .MARGIN(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .feat_valid  (feat_valid),
      .feat_in     (feat_in),
      .clear       (clear),
      .ack         (ack),
      .busy        (busy),
      .class_idx   (class_idx),
      .class_valid (class_valid),
      .seg         (seg),
      .overrun     (overrun),
      .low_conf    (low_conf)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cur_cycle++;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ack"},         32'(ack),         0);
      chk({tag, "_busy"},        32'(busy),        0);
      chk({tag, "_class_idx"},   32'(class_idx),   0);
      chk({tag, "_class_valid"}, 32'(class_valid), 0);
      chk({tag, "_seg"},         32'(seg),         32'h0FF);
      chk({tag, "_overrun"},     32'(overrun),     0);
      chk({tag, "_low_conf"},    32'(low_conf),    0);
   endtask

   // Reference: lowest index of the max, second = max over all other entries.
   function automatic logic [EW-1:0] model();
      logic signed [7:0] best;
      logic signed [7:0] second;
      int bi;
      int gap;
      logic lc;
      logic [7:0] s;
      best = sc[0];
      bi   = 0;
      for (int i = 1; i < N; i++) begin
         if (sc[i] > best) begin
            best = sc[i];
            bi   = i;
         end
      end
      second = -8'sd128;
      for (int i = 0; i < N; i++) begin
         if (i != bi && sc[i] > second) second = sc[i];
      end
      gap = int'(best) - int'(second);
`ifdef MARGIN_CHECK_EN
      lc = (gap < 4);
`else
      lc = 1'b0;
      if (gap < 0) lc = 1'b1;
`endif
      s = lut[bi];
      s[7] = ~lc;
      return {4'(bi), s, lc};
   endfunction

   // ---------------- driver ----------------
   task automatic pack_scores();
      for (int i = 0; i < N; i++) feat_in[i*W +: W] = sc[i];
   endtask

   task automatic fill(input logic signed [7:0] v);
      for (int i = 0; i < N; i++) sc[i] = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic start_run(input bit push);
      pack_scores();
      if (push) exp_q.push_back(model());
      feat_valid = 1'b1;
      @(posedge clk);
      #1;
      feat_valid = 1'b0;
      cur_cycle = 1;
      chk("busy_after_capture", 32'(busy), 1);
      chk("no_early_ack", 32'(ack), 0);
   endtask

   task automatic wait_report(input bit clr_at_ack);
      logic [EW-1:0] e;
      while (!ack && cur_cycle < 40) step(1);
      chk("ack_seen", 32'(ack), 1);
      chk("ack_latency", 32'(cur_cycle), 17);
      chk("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
      if (ack && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         last_seg = e[8:1];
         chk("class_idx",   32'(class_idx),   32'(e[12:9]));
         chk("seg",         32'(seg),         32'(e[8:1]));
         chk("low_conf",    32'(low_conf),    32'(e[0]));
         chk("class_valid", 32'(class_valid), 1);
         chk("busy_at_report", 32'(busy), 1);
      end
      clear = clr_at_ack;
      step(1);
      clear = 1'b0;
      chk("ack_one_cycle", 32'(ack), 0);
      chk("busy_after_report", 32'(busy), 0);
      if (clr_at_ack) begin
         chk("report_beats_clear", 32'(class_valid), 1);
         chk("clear_overrun_at_report", 32'(overrun), 0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acks;
      lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      rst = 1'b1;
      feat_valid = 1'b0;
      clear = 1'b0;
      feat_in = '0;
      step(3);
      rst = 1'b0;
      check_reset("reset");

      // single clear winner
      fill(0); sc[5] = 8'sd100;
      start_run(1'b1);
      wait_report(1'b0);
      chk("t1_seg_table", 32'(seg), 32'h92);
      chk("t1_idx", 32'(class_idx), 5);

      // tie goes to lowest index
      fill(-8'sd10); sc[3] = 8'sd50; sc[9] = 8'sd50;
      start_run(1'b1);
      wait_report(1'b0);
      chk("t2_idx", 32'(class_idx), 3);

      // signed extremes, winner at last index
      fill(-8'sd128); sc[15] = -8'sd1;
      start_run(1'b1);
      wait_report(1'b0);
      chk("t3_seg_table", 32'(seg), 32'h8E);

      for (int r = 0; r < 3; r++) begin
         fill_random();
         start_run(1'b1);
         wait_report(1'b0);
      end

      // second rise mid-scan with new data: ignored, overrun set, held high afterwards
      fill(-8'sd5); sc[7] = 8'sd60;
      start_run(1'b1);
      step(5);
      fill(0); sc[1] = 8'sd120;
      pack_scores();
      feat_valid = 1'b1;
      step(1);
      chk("t4_overrun", 32'(overrun), 1);
      wait_report(1'b0);
      step(3);
      chk("t4_held_no_retrigger", 32'(busy), 0);
      feat_valid = 1'b0;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("t4_clear_overrun", 32'(overrun), 0);
      chk("t4_clear_valid", 32'(class_valid), 0);
      chk("t4_seg_holds", 32'(seg), 32'(last_seg));

      // reset mid-scan aborts without ack
      fill_random();
      start_run(1'b0);
      step(7);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_reset("t5_reset");
      acks = 0;
      repeat (25) begin
         step(1);
         if (ack) acks++;
      end
      chk("t5_no_ack", 32'(acks), 0);
      fill(8'sd3); sc[11] = 8'sd90;
      start_run(1'b1);
      wait_report(1'b0);

      // overrun then clear in the report cycle
      fill_random();
      start_run(1'b1);
      step(3);
      feat_valid = 1'b1;
      step(1);
      feat_valid = 1'b0;
      chk("t7_overrun", 32'(overrun), 1);
      wait_report(1'b1);

      // margin: gap 2 then gap 4
      fill(-8'sd50); sc[2] = 8'sd20; sc[9] = 8'sd18;
      start_run(1'b1);
      wait_report(1'b0);
`ifdef MARGIN_CHECK_EN
      chk("t6_narrow_seg", 32'(seg), 32'h24);
      chk("t6_narrow_lc", 32'(low_conf), 1);
`else
      chk("t6_narrow_seg", 32'(seg), 32'hA4);
      chk("t6_narrow_lc", 32'(low_conf), 0);
`endif
      sc[9] = 8'sd16;
      start_run(1'b1);
      wait_report(1'b0);
      chk("t6_gap4_seg", 32'(seg), 32'hA4);
      chk("t6_gap4_lc", 32'(low_conf), 0);

      chk("exp_q_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
